// File: rtl/uart_pkg.sv
// Shared constants and FSM encoding for the oversampling UART receiver.
package uart_pkg;
    localparam int OVERSAMPLE_DEF = 16;
    localparam int FRAME_BITS     = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } uart_state_e;
endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module uart_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic s1_q, s2_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;
endmodule

// File: rtl/uar_top.sv
// 8N1 UART receiver: start-bit qualification at MID, data/stop sampled one bit period apart.
module uar_top
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int MID        = OVERSAMPLE / 2 - 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       ser_in,
    input  logic       dout_ack,
    output logic [7:0] dout_byte,
    output logic       dout_rdy,
    output logic       frame_err,
    output logic       overrun,
    output logic       uart_busy,
    output logic [3:0] shift_count
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TCNT_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TCNT_MID  = TW'(MID);
    localparam logic [3:0]    LAST_BIT  = 4'(FRAME_BITS - 1);

    logic rx_s;

    uart_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ser_in),
        .q     (rx_s)
    );

    uart_state_e           state_q, state_d;
    logic [TW-1:0]         tcnt_q, tcnt_d;
    logic [FRAME_BITS-1:0] shreg_q, shreg_d;
    logic [FRAME_BITS-1:0] byte_q, byte_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  rdy_q, rdy_d;
    logic                  ferr_q, ferr_d;
    logic                  ovr_q, ovr_d;
    logic                  load;

    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        byte_d  = byte_q;
        rdy_d   = rdy_q;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;
        load    = 1'b0;

        if (enable) begin
            case (state_q)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_d = ST_START;
                        tcnt_d  = '0;
                        cnt_d   = '0;
                    end
                end
                ST_START: begin
                    if (tcnt_q == TCNT_MID) begin
                        tcnt_d  = '0;
                        state_d = rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (tcnt_q == TCNT_LAST) begin
                        // LSB arrives first, so shifting in at the MSB leaves it at bit 0 after 8 bits.
                        shreg_d = {rx_s, shreg_q[FRAME_BITS-1:1]};
                        cnt_d   = cnt_q + 1'b1;
                        tcnt_d  = '0;
                        if (cnt_q == LAST_BIT) state_d = ST_STOP;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (tcnt_q == TCNT_LAST) begin
                        tcnt_d = '0;
                        if (rx_s) begin
                            load    = 1'b1;
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = ST_BREAK;
                        end
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
                ST_BREAK: begin
                    if (rx_s) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // A completing byte wins over a same-cycle ack: the fresh byte stays ready.
        if (load) begin
            byte_d = shreg_q;
            rdy_d  = 1'b1;
            ovr_d  = rdy_q && !dout_ack;
        end else if (dout_ack) begin
            rdy_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            tcnt_q  <= '0;
            shreg_q <= '0;
            byte_q  <= '0;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            shreg_q <= shreg_d;
            byte_q  <= byte_d;
            cnt_q   <= cnt_d;
            rdy_q   <= rdy_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign dout_byte   = byte_q;
    assign dout_rdy    = rdy_q;
    assign frame_err   = ferr_q;
    assign overrun     = ovr_q;
    assign uart_busy   = (state_q != ST_IDLE);
    assign shift_count = cnt_q;
endmodule

// File: tb/tb_uar_top.sv
// Randomized bench for uar_top with a phase-arithmetic reference receiver checked every cycle.
module tb_uar_top;
    localparam int OS  = 16;
    localparam int MID = OS / 2 - 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       ser_in = 1'b1;
    logic       dout_ack = 1'b0;
    logic [7:0] dout_byte;
    logic       dout_rdy, frame_err, overrun, uart_busy;
    logic [3:0] shift_count;

    logic       ser8 = 1'b1;
    logic       ack8 = 1'b0;
    logic [7:0] dout_byte8;
    logic       dout_rdy8, frame_err8, overrun8, uart_busy8;
    logic [3:0] shift_count8;

    always #5 clk = ~clk;

    uar_top #(.OVERSAMPLE(16)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .ser_in(ser_in), .dout_ack(dout_ack),
        .dout_byte(dout_byte), .dout_rdy(dout_rdy), .frame_err(frame_err), .overrun(overrun),
        .uart_busy(uart_busy), .shift_count(shift_count)
    );

    uar_top #(.OVERSAMPLE(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .ser_in(ser8), .dout_ack(ack8),
        .dout_byte(dout_byte8), .dout_rdy(dout_rdy8), .frame_err(frame_err8), .overrun(overrun8),
        .uart_busy(uart_busy8), .shift_count(shift_count8)
    );

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Reference receiver: a frame is tracked as the number of enable ticks since the
    // start edge was seen; samples fall at MID+1 and then every OS ticks after that.
    int         m_ph = -1;
    bit         m_brk = 0;
    logic [7:0] m_acc = 8'h00, m_byte = 8'h00;
    bit         m_rdy = 0, m_ferr = 0, m_ovr = 0;
    int         m_cnt = 0;
    bit         m_s1 = 1, m_s2 = 1;

    always @(posedge clk) begin : mdl
        bit rx, done;
        int k;
        if (!rst_n) begin
            m_ph = -1; m_brk = 0; m_acc = 8'h00; m_byte = 8'h00;
            m_rdy = 0; m_ferr = 0; m_ovr = 0; m_cnt = 0; m_s1 = 1; m_s2 = 1;
        end else begin
            rx = m_s2; m_s2 = m_s1; m_s1 = ser_in;
            m_ferr = 0; m_ovr = 0; done = 0;
            if (enable) begin
                if (m_brk) begin
                    if (rx) begin m_brk = 0; m_cnt = 0; end
                end else if (m_ph < 0) begin
                    if (!rx) begin m_ph = 0; m_cnt = 0; end
                end else begin
                    m_ph++;
                    if (m_ph == MID + 1) begin
                        if (rx) m_ph = -1;
                    end else if (m_ph > MID + 1 && (m_ph - MID - 1) % OS == 0) begin
                        k = (m_ph - MID - 1) / OS;
                        if (k <= 8) begin
                            m_acc[k-1] = rx;
                            m_cnt = k;
                        end else begin
                            m_ph = -1;
                            if (rx) begin done = 1; m_cnt = 0; end
                            else begin m_ferr = 1; m_brk = 1; end
                        end
                    end
                end
            end
            if (done) begin
                m_ovr  = m_rdy && !dout_ack;
                m_byte = m_acc;
                m_rdy  = 1;
            end else if (dout_ack) begin
                m_rdy = 0;
            end
        end
    end

    bit cmp_on = 0;
    int ferr_cnt = 0, ovr_cnt = 0, rdy_rise = 0;
    bit rdy_prev = 0;

    always @(negedge clk) begin
        if (cmp_on) begin
            checks++;
            if ({dout_byte, dout_rdy, frame_err, overrun, uart_busy, shift_count} ===
                {m_byte, m_rdy, m_ferr, m_ovr, (m_ph >= 0) || m_brk, 4'(m_cnt)})
                passes++;
            else
                $display("FAIL cycle @%0t: got byte=%h rdy=%b ferr=%b ovr=%b busy=%b cnt=%0d, expected byte=%h rdy=%b ferr=%b ovr=%b busy=%b cnt=%0d",
                         $time, dout_byte, dout_rdy, frame_err, overrun, uart_busy, shift_count,
                         m_byte, m_rdy, m_ferr, m_ovr, (m_ph >= 0) || m_brk, m_cnt);
            if (frame_err) ferr_cnt++;
            if (overrun) ovr_cnt++;
            if (dout_rdy && !rdy_prev) rdy_rise++;
            rdy_prev = dout_rdy;
        end
    end

    // ack_mode: 0 never, 1 random, 2 five clocks after ready, 3 exactly on stop sample, 4 always
    int ack_mode = 0;
    int rdy_age = 0;
    bit cnt_busy = 0;
    int busy_ticks = 0;

    task automatic step();
        @(negedge clk);
        enable = ($urandom_range(0, 2) == 0);
        case (ack_mode)
            1: dout_ack = ($urandom_range(0, 7) == 0);
            2: begin
                if (dout_rdy) rdy_age++; else rdy_age = 0;
                dout_ack = (rdy_age == 5);
            end
            3: dout_ack = enable && !m_brk && (m_ph == MID + OS * 9);
            4: dout_ack = 1'b1;
            default: dout_ack = 1'b0;
        endcase
        if (cnt_busy && enable && uart_busy) busy_ticks++;
    endtask

    task automatic tick();
        do step(); while (!enable);
    endtask

    task automatic send_bits(input bit v, input int n, input bit on8);
        if (on8) ser8 = v; else ser_in = v;
        repeat (n) tick();
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop, input int os, input bit on8);
        send_bits(1'b0, os, on8);
        for (int i = 0; i < 8; i++) send_bits(b[i], os, on8);
        send_bits(stop, os, on8);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0, o0;
        logic [7:0] rb;
        repeat (3) step();
        rst_n = 1'b1;
        cmp_on = 1;
        step();
        chk("reset dout_byte", dout_byte, 8'h00);
        chk("reset dout_rdy", dout_rdy, 1'b0);
        chk("reset uart_busy", uart_busy, 1'b0);
        chk("reset shift_count", shift_count, 4'd0);
        chk("reset frame_err", frame_err, 1'b0);
        chk("reset8 dout_byte", dout_byte8, 8'h00);

        // 0xAA, acked five clocks after ready
        ack_mode = 2;
        send_bits(1'b1, 20, 0);
        send_frame(8'hAA, 1'b1, OS, 0);
        send_bits(1'b1, 30, 0);
        chk("AA model byte", m_byte, 8'hAA);
        chk("AA dout_byte", dout_byte, 8'hAA);
        chk("AA rdy cleared by ack", dout_rdy, 1'b0);
        chk("AA rdy rises", rdy_rise, 1);
        chk("AA no frame_err", ferr_cnt, 0);
        chk("AA no overrun", ovr_cnt, 0);

        // short low glitch is rejected as a false start
        ack_mode = 0;
        cnt_busy = 1;
        send_bits(1'b0, 3, 0);
        send_bits(1'b1, 20, 0);
        cnt_busy = 0;
        chk("glitch rdy stays 0", dout_rdy, 1'b0);
        chk("glitch busy ticks <= 8", busy_ticks <= 8, 1'b1);
        chk("glitch busy seen", busy_ticks > 0, 1'b1);
        chk("glitch idle", uart_busy, 1'b0);

        // 0x55 with bad stop, then line held low
        f0 = ferr_cnt;
        send_frame(8'h55, 1'b0, OS, 0);
        send_bits(1'b0, 40, 0);
        chk("break busy while low", uart_busy, 1'b1);
        chk("break one frame_err", ferr_cnt - f0, 1);
        chk("break byte kept", dout_byte, 8'hAA);
        send_bits(1'b1, 10, 0);
        chk("break exits when high", uart_busy, 1'b0);

        // back-to-back without ack -> overrun
        o0 = ovr_cnt;
        send_frame(8'h00, 1'b1, OS, 0);
        send_bits(1'b1, 1, 0);
        send_frame(8'hFF, 1'b1, OS, 0);
        send_bits(1'b1, 4, 0);
        chk("ovr byte FF", dout_byte, 8'hFF);
        chk("ovr model byte", m_byte, 8'hFF);
        chk("ovr one pulse", ovr_cnt - o0, 1);
        ack_mode = 4; step(); ack_mode = 0; step();
        chk("ovr rdy acked", dout_rdy, 1'b0);

        // same, but ack lands on the second completion
        o0 = ovr_cnt;
        send_frame(8'h00, 1'b1, OS, 0);
        send_bits(1'b1, 1, 0);
        ack_mode = 3;
        send_frame(8'hFF, 1'b1, OS, 0);
        ack_mode = 0;
        send_bits(1'b1, 4, 0);
        chk("coinc byte FF", dout_byte, 8'hFF);
        chk("coinc rdy stays", dout_rdy, 1'b1);
        chk("coinc no overrun", ovr_cnt - o0, 0);

        // reset during data bit 4 of 0x3C, then clean 0xC3
        rb = 8'h3C;
        send_bits(1'b0, OS, 0);
        for (int i = 0; i < 4; i++) send_bits(rb[i], OS, 0);
        send_bits(rb[4], OS / 2, 0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        ser_in = 1'b1;
        chk("midrst dout_byte", dout_byte, 8'h00);
        chk("midrst dout_rdy", dout_rdy, 1'b0);
        chk("midrst uart_busy", uart_busy, 1'b0);
        chk("midrst shift_count", shift_count, 4'd0);
        send_bits(1'b1, 20, 0);
        send_frame(8'hC3, 1'b1, OS, 0);
        send_bits(1'b1, 10, 0);
        chk("C3 dout_byte", dout_byte, 8'hC3);
        chk("C3 dout_rdy", dout_rdy, 1'b1);

        // randomized traffic
        ack_mode = 1;
        for (int n = 0; n < 25; n++) begin
            bit bad;
            bad = ($urandom_range(0, 5) == 0);
            send_frame(8'($urandom_range(0, 255)), !bad, OS, 0);
            if (bad) send_bits(1'b0, $urandom_range(0, 20), 0);
            send_bits(1'b1, $urandom_range(1, 6), 0);
        end
        ack_mode = 0;
        send_bits(1'b1, 10, 0);

        // 8x oversampling build
        send_bits(1'b1, 10, 1);
        send_frame(8'h81, 1'b1, 8, 1);
        send_bits(1'b1, 10, 1);
        chk("os8 dout_byte", dout_byte8, 8'h81);
        chk("os8 dout_rdy", dout_rdy8, 1'b1);
        chk("os8 idle", uart_busy8, 1'b0);

        cmp_on = 0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/uar_top.md
UAR_TOP -- requirements
Module: uar_top

Interface
REQ-001 Parameter OVERSAMPLE, default 16; enable ticks per bit period; legal values 8 or 16.
REQ-002 Parameter MID, default OVERSAMPLE/2-1; tick index within a bit at which the line is sampled.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset; synchronous and active-low, sampled on the rising edge of clk.
REQ-005 enable  input  1  oversample tick; one-clk pulse, OVERSAMPLE pulses per bit period.
REQ-006 ser_in  input  1  asynchronous serial line; idle high; frame is 8N1, LSB first.
REQ-007 dout_ack  input  1  consumer acknowledges dout_byte; clears dout_rdy.
REQ-008 dout_byte  output  8  last correctly framed byte.
REQ-009 dout_rdy  output  1  level; dout_byte holds an unacknowledged byte.
REQ-010 frame_err  output  1  one-clk pulse; stop bit sampled low.
REQ-011 overrun  output  1  one-clk pulse; new byte written while dout_rdy=1 with no ack that cycle.
REQ-012 uart_busy  output  1  high whenever state is not IDLE.
REQ-013 shift_count  output  4  number of data bits received in the current frame, 0..8.

Function
REQ-014 ser_in SHALL pass through a 2-FF synchronizer; all logic uses the synchronized value rx_s.
REQ-015 FSM states SHALL be IDLE, START, DATA, STOP, BREAK; tick counter tcnt is log2(OVERSAMPLE) bits.
REQ-016 IDLE: on enable with rx_s=0 -> START, tcnt=0, shift_count=0.
REQ-017 START: tcnt increments on enable; at enable with tcnt=MID, rx_s=0 -> DATA with tcnt=0; rx_s=1 -> IDLE with no output (false start).
REQ-018 DATA: at every enable with tcnt=OVERSAMPLE-1 (mid-bit), rx_s SHALL shift into the MSB of the shift register (LSB-first reassembly), shift_count increments, and tcnt wraps to 0; after the 8th bit -> STOP.
REQ-019 STOP: at mid-bit tick, rx_s=1 -> load dout_byte, set dout_rdy, go IDLE; rx_s=0 -> pulse frame_err, leave dout_byte/dout_rdy unchanged, go BREAK.
REQ-020 BREAK: remain until rx_s=1 on an enable tick, then IDLE; a held-low line produces exactly one frame_err.
REQ-021 Cycles without enable SHALL change neither tcnt nor state, except the synchronizer.
REQ-022 dout_rdy SHALL be set in the clk after the stop-bit sample tick and cleared in the clk after dout_ack=1.
REQ-023 Byte completion and dout_ack in the same cycle: dout_rdy stays 1, new byte is loaded, no overrun.
REQ-024 Byte completion with dout_rdy=1 and dout_ack=0: new byte overwrites, overrun pulses one clk.
REQ-025 dout_ack with dout_rdy=0 SHALL have no effect.
REQ-026 shift_count SHALL hold 8 through STOP and return to 0 on entry to IDLE.

Reset
REQ-027 rst_n=0 at a rising edge SHALL force IDLE, tcnt=0, shift register=0, dout_byte=8'h00, dout_rdy=0, frame_err=0, overrun=0, uart_busy=0, shift_count=0, and both synchronizer flops to 1.
REQ-028 Reset mid-frame SHALL discard the partial byte; reception resumes only at the next falling edge after rst_n=1.

Structure
REQ-029 Shared package uart_pkg SHALL hold the FSM state encoding, OVERSAMPLE default, and the frame width constant (8).
REQ-030 The 2-FF synchronizer SHALL be a separate sub-module uart_sync; all other logic is in uar_top.

Verification
REQ-031 Frame 0xAA at 16 ticks/bit, ack 5 clk after dout_rdy -> dout_byte=0xAA, dout_rdy high until ack, no frame_err/overrun.
REQ-032 Low glitch lasting 3 ticks on an idle line -> returns to IDLE, dout_rdy stays 0, uart_busy high for at most 8 ticks.
REQ-033 Frame 0x55 with stop bit 0, then line low for 40 ticks -> one frame_err pulse, dout_byte unchanged, BREAK until line high.
REQ-034 Back-to-back 0x00 then 0xFF, no ack -> dout_byte=0xFF, one overrun pulse; repeated with ack coincident with the second completion -> no overrun.
REQ-035 rst_n low for 1 clk during data bit 4 of 0x3C, then a clean 0xC3 frame -> all outputs at reset values, then dout_byte=0xC3.
REQ-036 OVERSAMPLE=8 build, frame 0x81 -> dout_byte=0x81, dout_rdy set.
